alu_matrix_top: RTL and testbench

- Register-based 3x3 matrix ALU with 32-bit elements.
- Two operand matrices, A and B, are loaded one element at a time through a single select/data port.
- An operation selected by the same port writes its result into a result matrix C.
- C is read back one element at a time on eleOut; the block is a standalone compute peripheral driven by a host sequencer.

---
 rtl/alu_matrix_top.sv | 100 ++++++++++
 tb/tb_alu_matrix_top.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_matrix_top.sv
// 3x3 matrix ALU: operand matrices A and B are loaded element by element,
// a command selects an operation whose result lands in C, and C is read back on eleOut.
module alu_matrix_top #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [5:0]   sel,
  input  logic [W-1:0] eleIn,
  output logic [W-1:0] eleOut
);

  localparam logic [5:0] SEL_A_BASE = 6'd0;
  localparam logic [5:0] SEL_B_BASE = 6'd9;
  localparam logic [5:0] SEL_R_BASE = 6'd18;
  localparam logic [5:0] OP_ADD     = 6'd27;
  localparam logic [5:0] OP_TRANS   = 6'd28;
  localparam logic [5:0] OP_SUB     = 6'd29;
  localparam logic [5:0] OP_MATMUL  = 6'd30;
  localparam logic [5:0] OP_SCALE   = 6'd31;

  logic [W-1:0] a_q [9];
  logic [W-1:0] a_d [9];
  logic [W-1:0] b_q [9];
  logic [W-1:0] b_d [9];
  logic [W-1:0] c_q [9];
  logic [W-1:0] c_d [9];

  logic [W-1:0] sum_m   [9];
  logic [W-1:0] diff_m  [9];
  logic [W-1:0] trans_m [9];
  logic [W-1:0] scale_m [9];
  logic [W-1:0] prod_m  [9];

  // Row-by-column dot product, truncated to W bits (modulo 2^W).
  function automatic logic [W-1:0] dot3(
    input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] a2,
    input logic [W-1:0] b0, input logic [W-1:0] b1, input logic [W-1:0] b2
  );
    logic [W-1:0] p0, p1, p2;
    p0 = a0 * b0;
    p1 = a1 * b1;
    p2 = a2 * b2;
    return p0 + p1 + p2;
  endfunction

  // All candidate results are formed from A, B and eleIn only, never from C,
  // so holding an op command simply recomputes the same value each edge.
  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign sum_m[3*r+c]   = a_q[3*r+c] + b_q[3*r+c];
      assign diff_m[3*r+c]  = a_q[3*r+c] - b_q[3*r+c];
      assign trans_m[3*r+c] = a_q[3*c+r];
      assign scale_m[3*r+c] = a_q[3*r+c] * eleIn;
      assign prod_m[3*r+c]  = dot3(a_q[3*r], a_q[3*r+1], a_q[3*r+2],
                                   b_q[c], b_q[3+c], b_q[6+c]);
    end
  end

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    for (int k = 0; k < 9; k++) begin
      if (sel == SEL_A_BASE + 6'(k)) a_d[k] = eleIn;
      if (sel == SEL_B_BASE + 6'(k)) b_d[k] = eleIn;
    end
    case (sel)
      OP_ADD:    c_d = sum_m;
      OP_TRANS:  c_d = trans_m;
      OP_SUB:    c_d = diff_m;
      OP_MATMUL: c_d = prod_m;
      OP_SCALE:  c_d = scale_m;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 9; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end

  // Read port is purely combinational: a read select shows C without waiting for an edge.
  always_comb begin
    eleOut = '0;
    for (int k = 0; k < 9; k++) begin
      if (sel == SEL_R_BASE + 6'(k)) eleOut = c_q[k];
    end
  end

endmodule

// File: tb/tb_alu_matrix_top.sv
// Directed bench for alu_matrix_top: loads operands, issues each op and
// compares every read of C against hand-computed values.
module tb_alu_matrix_top;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [5:0]   sel;
  logic [W-1:0] eleIn;
  logic [W-1:0] eleOut;

  int total_cnt;
  int bad_cnt;
  logic [W-1:0] exp_q[$];

  alu_matrix_top #(.W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .eleIn  (eleIn),
    .eleOut (eleOut)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drivers: commands change on the falling edge and take effect on the next rising edge.
  task automatic issue(input logic [5:0] s, input logic [W-1:0] v);
    @(negedge clk);
    sel   = s;
    eleIn = v;
    @(negedge clk);
    sel   = 6'd40;
  endtask

  task automatic load_a(input int k, input logic [W-1:0] v);
    issue(6'(k), v);
  endtask

  task automatic load_b(input int k, input logic [W-1:0] v);
    issue(6'(k + 9), v);
  endtask

  task automatic load_seq_ab(input bit do_a, input bit do_b);
    for (int k = 0; k < 9; k++) begin
      if (do_a) load_a(k, W'(k));
      if (do_b) load_b(k, W'(k));
    end
  endtask

  task automatic read_c(input string tag, input int k, input logic [W-1:0] exp);
    sel = 6'(18 + k);
    #1;
    check_eq($sformatf("%s_c%0d", tag, k), eleOut, exp);
  endtask

  // Scoreboard: drain exp_q against C[0..8] in order.
  task automatic read_all(input string tag);
    logic [W-1:0] e;
    for (int k = 0; k < 9; k++) begin
      if (exp_q.size() == 0) begin
        check_eq({tag, "_noexp"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        read_c(tag, k, e);
      end
    end
    sel = 6'd40;
  endtask

  task automatic push9(input logic [W-1:0] v0, input logic [W-1:0] v1, input logic [W-1:0] v2,
                       input logic [W-1:0] v3, input logic [W-1:0] v4, input logic [W-1:0] v5,
                       input logic [W-1:0] v6, input logic [W-1:0] v7, input logic [W-1:0] v8);
    exp_q.push_back(v0); exp_q.push_back(v1); exp_q.push_back(v2);
    exp_q.push_back(v3); exp_q.push_back(v4); exp_q.push_back(v5);
    exp_q.push_back(v6); exp_q.push_back(v7); exp_q.push_back(v8);
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    reset     = 1'b1;
    sel       = 6'd5;
    eleIn     = 32'h1234_5678;

    // 1: reset state
    #1 reset = 1'b0;
    #1 check_eq("rst_sel5", eleOut, 32'd0);
    repeat (5) @(posedge clk);
    #1 check_eq("rst_sel5_after_edges", eleOut, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    sel   = 6'd40;
    push9(0, 0, 0, 0, 0, 0, 0, 0, 0);
    read_all("reset");

    // 2: transpose
    load_seq_ab(1'b1, 1'b0);
    issue(6'd28, 32'd0);
    push9(0, 3, 6, 1, 4, 7, 2, 5, 8);
    read_all("trans");

    // 6: no-op hold, then asynchronous reset mid-cycle
    @(negedge clk);
    sel   = 6'd40;
    eleIn = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1 check_eq("nop_read_zero", eleOut, 32'd0);
    push9(0, 3, 6, 1, 4, 7, 2, 5, 8);
    read_all("hold");
    @(posedge clk);
    sel = 6'd19;
    #2 check_eq("pre_async_rst", eleOut, 32'd3);
    reset = 1'b0;
    #1 check_eq("async_rst", eleOut, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    sel   = 6'd40;

    // 3: add then subtract
    load_seq_ab(1'b1, 1'b1);
    issue(6'd27, 32'd0);
    push9(0, 2, 4, 6, 8, 10, 12, 14, 16);
    read_all("add");
    issue(6'd29, 32'd0);
    push9(0, 0, 0, 0, 0, 0, 0, 0, 0);
    read_all("sub");

    // 4: matrix product (A and B still hold 0..8)
    issue(6'd30, 32'd0);
    push9(15, 18, 21, 42, 54, 66, 69, 90, 111);
    read_all("mul");

    // 5: wraparound boundaries and scalar multiply
    load_a(0, 32'hFFFF_FFFF);
    load_b(0, 32'd2);
    issue(6'd27, 32'd0);
    read_c("wrap_add", 0, 32'd1);
    read_c("wrap_add", 1, 32'd2);
    load_a(0, 32'd0);
    load_b(0, 32'd1);
    issue(6'd29, 32'd0);
    read_c("wrap_sub", 0, 32'hFFFF_FFFF);
    read_c("wrap_sub", 1, 32'd0);
    issue(6'd31, 32'd3);
    read_c("scale", 4, 32'd12);
    read_c("scale", 8, 32'd24);
    load_a(0, 32'h8000_0001);
    issue(6'd31, 32'd2);
    read_c("scale_wrap", 0, 32'd2);
    read_c("scale_wrap", 1, 32'd2);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
